// File: rtl/exec_pkg.sv
// Shared execution-unit definitions: funct codes, result mux selects,
// sequencer states and the funct classifier used by decode blocks.
package exec_pkg;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MUL  = 6'b011001;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_SHT = 2'b01,
    SEL_HI  = 2'b10,
    SEL_LO  = 2'b11
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WRITE
  } seq_state_e;

  typedef struct packed {
    logic    legal;
    logic    is_mul;
    op_sel_e sel;
  } funct_dec_t;

  function automatic funct_dec_t decode_funct(input logic [5:0] f);
    funct_dec_t d;
    d.legal  = 1'b1;
    d.is_mul = 1'b0;
    d.sel    = SEL_ALU;
    unique case (1'b1)
      (f == F_AND),
      (f == F_OR),
      (f == F_ADD),
      (f == F_SUB),
      (f == F_SLT):  d.sel = SEL_ALU;
      (f == F_SRL):  d.sel = SEL_SHT;
      (f == F_MFHI): d.sel = SEL_HI;
      (f == F_MFLO): d.sel = SEL_LO;
      (f == F_MUL):  d.is_mul = 1'b1;
      default:       d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Issue/dispatch bundle between decode, the sequencer and the
// execution units.
interface mul_sequencer_if;
  logic       issue_valid;
  logic [5:0] issue_funct;
  logic       issue_ready;
  logic       flush;
  logic       op_valid;
  logic [5:0] op_funct;
  logic [1:0] op_sel;
  logic       illegal;
  logic       mul_load;
  logic       mul_step;
  logic       hilo_we;
  logic       hilo_valid;
  logic       busy;

  modport master (
    output issue_valid, issue_funct, flush,
    input  issue_ready, op_valid, op_funct, op_sel, illegal,
    input  mul_load, mul_step, hilo_we, hilo_valid, busy
  );

  modport slave (
    input  issue_valid, issue_funct, flush,
    output issue_ready, op_valid, op_funct, op_sel, illegal,
    output mul_load, mul_step, hilo_we, hilo_valid, busy
  );
endinterface

// File: rtl/mul_step_counter.sv
// Multiplier step counter: clears on request, counts while enabled
// and saturates at the terminal count.
module mul_step_counter #(
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW =
    (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mul_sequencer.sv
// Issue-side controller: single-cycle op dispatch plus the
// load/step/write-back sequence of the iterative multiplier.
import exec_pkg::*;

module mul_sequencer #(
  parameter int MUL_CYCLES = 32
) (
  input logic            clk,
  input logic            rst_n,
  mul_sequencer_if.slave bus
);
  seq_state_e state_q, state_d;
  logic       op_valid_q, op_valid_d;
  logic [5:0] op_funct_q, op_funct_d;
  logic [1:0] op_sel_q, op_sel_d;
  logic       illegal_q, illegal_d;
  logic       hilo_valid_q, hilo_valid_d;
  logic       ready;
  logic       accept;
  logic       cnt_clr;
  logic       cnt_tc;
  funct_dec_t dec;

  assign ready  = (state_q == ST_IDLE) & ~bus.flush;
  assign accept = bus.issue_valid & ready;
  assign dec    = decode_funct(bus.issue_funct);

  // Counter only runs inside RUN; any other state or a flush zeroes it.
  assign cnt_clr = (state_q != ST_RUN) | bus.flush;

  mul_step_counter #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (state_q == ST_RUN),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    op_valid_d   = 1'b0;
    illegal_d    = 1'b0;
    op_funct_d   = op_funct_q;
    op_sel_d     = op_sel_q;
    hilo_valid_d = hilo_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!dec.legal) begin
            illegal_d = 1'b1;
          end else if (dec.is_mul) begin
            state_d = ST_LOAD;
          end else begin
            op_valid_d = 1'b1;
            op_funct_d = bus.issue_funct;
            op_sel_d   = dec.sel;
          end
        end
      end
      ST_LOAD: begin
        state_d = bus.flush ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The write commits at this edge even if flush is raised.
        state_d      = ST_IDLE;
        hilo_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_valid_q   <= 1'b0;
      op_funct_q   <= '0;
      op_sel_q     <= SEL_ALU;
      illegal_q    <= 1'b0;
      hilo_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_valid_q   <= op_valid_d;
      op_funct_q   <= op_funct_d;
      op_sel_q     <= op_sel_d;
      illegal_q    <= illegal_d;
      hilo_valid_q <= hilo_valid_d;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_funct    = op_funct_q;
  assign bus.op_sel      = op_sel_q;
  assign bus.illegal     = illegal_q;
  assign bus.hilo_valid  = hilo_valid_q;
  assign bus.mul_load    = (state_q == ST_LOAD);
  assign bus.mul_step    = (state_q == ST_RUN);
  assign bus.hilo_we     = (state_q == ST_WRITE);
  assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: a 32-step and a 1-step instance checked
// against a cycle-count model of the issue/multiply timeline.
module tb_mul_sequencer;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_sequencer_if if32();
  mul_sequencer_if if1();

  mul_sequencer #(.MUL_CYCLES(N)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32)
  );
  mul_sequencer #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model of the registered op bundle and HI/LO status of dut32
  logic [5:0] m_funct = 6'd0;
  logic [1:0] m_sel = 2'd0;
  logic       m_hv = 1'b0;

  // -1 illegal, 0..3 result select, 4 MUL
  function automatic int ref_class(input logic [5:0] f);
    case (f)
      6'b100100, 6'b100101, 6'b100000,
      6'b100010, 6'b101010: return 0;
      6'b000010: return 1;
      6'b010000: return 2;
      6'b010010: return 3;
      6'b011001: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    if32.issue_valid = 0; if32.issue_funct = 0; if32.flush = 0;
    if1.issue_valid = 0;  if1.issue_funct = 0;  if1.flush = 0;
    rst_n = 0;
    repeat (2) tick();
    flags = {if32.op_valid, if32.illegal, if32.mul_load,
             if32.mul_step, if32.hilo_we, if32.hilo_valid, if32.busy};
    n_cmp++;
    if (flags !== 7'd0) begin
      n_err++; $display("FAIL reset_flags32: got %b want 0000000", flags);
    end
    n_cmp++;
    if ({if32.op_funct, if32.op_sel} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_op32: got %h/%b want 00/00",
               if32.op_funct, if32.op_sel);
    end
    flags = {if1.op_valid, if1.illegal, if1.mul_load,
             if1.mul_step, if1.hilo_we, if1.hilo_valid, if1.busy};
    n_cmp++;
    if (flags !== 7'd0) begin
      n_err++; $display("FAIL reset_flags1: got %b want 0000000", flags);
    end
    rst_n = 1;
    #1;
    n_cmp++;
    if ({if32.issue_ready, if1.issue_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready: got %b%b want 11",
               if32.issue_ready, if1.issue_ready);
    end
    m_funct = 0; m_sel = 0; m_hv = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] fl [4];
    fl[0] = 6'b100000; fl[1] = 6'b101010;
    fl[2] = 6'b000010; fl[3] = 6'b010010;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        if32.issue_valid = 1; if32.issue_funct = fl[i];
      end else begin
        if32.issue_valid = 0;
      end
      #1;
      if (i < 4) begin
        n_cmp++;
        if (if32.issue_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1",
                            i, if32.issue_ready);
        end
      end
      tick();
      if (i < 4) begin
        m_funct = fl[i];
        m_sel = 2'(ref_class(fl[i]));
      end
      n_cmp++;
      if (if32.op_valid !== (i < 4)) begin
        n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b",
                          i, if32.op_valid, (i < 4));
      end
      n_cmp++;
      if ({if32.op_funct, if32.op_sel} !== {m_funct, m_sel}) begin
        n_err++; $display("FAIL b2b_op[%0d]: got %h/%b want %h/%b",
                          i, if32.op_funct, if32.op_sel, m_funct, m_sel);
      end
    end
  endtask

  task automatic test_random_ops();
    logic [5:0] legal [8];
    logic [5:0] f;
    logic v, fl, acc, exp_v, exp_ill;
    int cls;
    legal[0] = 6'b100100; legal[1] = 6'b100101;
    legal[2] = 6'b100000; legal[3] = 6'b100010;
    legal[4] = 6'b101010; legal[5] = 6'b000010;
    legal[6] = 6'b010000; legal[7] = 6'b010010;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) < 8) begin
        f = legal[$urandom_range(0, 7)];
      end else begin
        f = 6'($urandom);
        if (ref_class(f) != -1) f = 6'b111111;
      end
      if32.issue_valid = v; if32.issue_funct = f; if32.flush = fl;
      #1;
      n_cmp++;
      if (if32.issue_ready !== !fl) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b",
                          i, if32.issue_ready, !fl);
      end
      tick();
      acc = v & !fl;
      cls = ref_class(f);
      exp_v = acc && (cls >= 0) && (cls < 4);
      exp_ill = acc && (cls < 0);
      if (exp_v) begin
        m_funct = f; m_sel = 2'(cls);
      end
      n_cmp++;
      if ({if32.op_valid, if32.illegal} !== {exp_v, exp_ill}) begin
        n_err++; $display("FAIL rnd_pulse[%0d]: got %b%b want %b%b", i,
                          if32.op_valid, if32.illegal, exp_v, exp_ill);
      end
      n_cmp++;
      if ({if32.op_funct, if32.op_sel} !== {m_funct, m_sel}) begin
        n_err++; $display("FAIL rnd_op[%0d]: got %h/%b want %h/%b", i,
                          if32.op_funct, if32.op_sel, m_funct, m_sel);
      end
    end
    if32.issue_valid = 0; if32.flush = 0;
  endtask

  task automatic start_mul32();
    if32.issue_valid = 1; if32.issue_funct = 6'b011001; if32.flush = 0;
    #1;
    n_cmp++;
    if (if32.issue_ready !== 1'b1) begin
      n_err++; $display("FAIL mul_start_ready: got %b want 1",
                        if32.issue_ready);
    end
    tick();
    if32.issue_valid = 0;
  endtask

  task automatic test_mul(input bit hold_mfhi);
    logic [5:0] got, exp;
    start_mul32();
    if (hold_mfhi) begin
      if32.issue_valid = 1; if32.issue_funct = 6'b010000;
    end
    for (int k = 1; k <= N + 4; k++) begin
      got = {if32.mul_load, if32.mul_step, if32.hilo_we,
             if32.busy, if32.issue_ready, if32.hilo_valid};
      exp = {k == 1, k >= 2 && k <= N + 1, k == N + 2,
             k <= N + 2, k >= N + 3, (k >= N + 3) ? 1'b1 : m_hv};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mul_seq k=%0d: got %b want %b",
                          k, got, exp);
      end
      n_cmp++;
      if (if32.op_valid !== (hold_mfhi && k == N + 4)) begin
        n_err++; $display("FAIL mul_opv k=%0d: got %b want %b",
                          k, if32.op_valid, hold_mfhi && k == N + 4);
      end
      if (hold_mfhi && k == N + 4) begin
        n_cmp++;
        if ({if32.op_funct, if32.op_sel} !== 8'b010000_10) begin
          n_err++; $display("FAIL mfhi_op: got %h/%b want 10/10",
                            if32.op_funct, if32.op_sel);
        end
        if32.issue_valid = 0;
      end
      tick();
    end
    m_hv = 1;
    if (hold_mfhi) begin
      m_funct = 6'b010000; m_sel = 2'b10;
    end
  endtask

  task automatic test_flush_run();
    int we_seen = 0;
    start_mul32();
    for (int k = 1; k <= 12; k++) begin
      if (if32.hilo_we) we_seen++;
      n_cmp++;
      if (if32.busy !== 1'b1) begin
        n_err++; $display("FAIL frun_busy k=%0d: got %b want 1",
                          k, if32.busy);
      end
      if (k == 12) if32.flush = 1;
      if (k < 12) tick();
    end
    tick();
    if32.flush = 0;
    #1;
    n_cmp++;
    if ({if32.busy, if32.mul_step, if32.issue_ready} !== 3'b001) begin
      n_err++; $display("FAIL frun_idle: got %b%b%b want 001",
                        if32.busy, if32.mul_step, if32.issue_ready);
    end
    for (int k = 0; k < N + 4; k++) begin
      if (if32.hilo_we) we_seen++;
      tick();
    end
    n_cmp++;
    if (we_seen != 0) begin
      n_err++; $display("FAIL frun_we: got %0d pulses want 0", we_seen);
    end
    n_cmp++;
    if (if32.hilo_valid !== m_hv) begin
      n_err++; $display("FAIL frun_hv: got %b want %b",
                        if32.hilo_valid, m_hv);
    end
  endtask

  task automatic test_flush_write();
    int we_seen = 0;
    start_mul32();
    for (int k = 1; k <= N + 2; k++) begin
      if (if32.hilo_we) we_seen++;
      if (k == N + 2) begin
        n_cmp++;
        if ({if32.hilo_we, if32.hilo_valid} !== {1'b1, m_hv}) begin
          n_err++; $display("FAIL fwr_write: got %b%b want 1%b",
                            if32.hilo_we, if32.hilo_valid, m_hv);
        end
        if32.flush = 1;
      end
      tick();
    end
    if32.flush = 0;
    if (if32.hilo_we) we_seen++;
    m_hv = 1;
    n_cmp++;
    if ({if32.busy, if32.hilo_valid} !== 2'b01) begin
      n_err++; $display("FAIL fwr_after: got %b%b want 01",
                        if32.busy, if32.hilo_valid);
    end
    n_cmp++;
    if (we_seen != 1) begin
      n_err++; $display("FAIL fwr_we: got %0d pulses want 1", we_seen);
    end
  endtask

  task automatic test_illegal_flush();
    if32.issue_valid = 1; if32.issue_funct = 6'b111111;
    tick();
    if32.issue_valid = 0;
    n_cmp++;
    if ({if32.illegal, if32.op_valid} !== 2'b10) begin
      n_err++; $display("FAIL ill_pulse: got %b%b want 10",
                        if32.illegal, if32.op_valid);
    end
    n_cmp++;
    if ({if32.op_funct, if32.op_sel} !== {m_funct, m_sel}) begin
      n_err++; $display("FAIL ill_hold: got %h/%b want %h/%b",
                        if32.op_funct, if32.op_sel, m_funct, m_sel);
    end
    tick();
    n_cmp++;
    if (if32.illegal !== 1'b0) begin
      n_err++; $display("FAIL ill_clear: got %b want 0", if32.illegal);
    end
    for (int i = 0; i < 2; i++) begin
      if32.issue_valid = 1; if32.flush = 1;
      if32.issue_funct = (i == 0) ? 6'b100000 : 6'b011001;
      #1;
      n_cmp++;
      if (if32.issue_ready !== 1'b0) begin
        n_err++; $display("FAIL fidle_ready[%0d]: got %b want 0",
                          i, if32.issue_ready);
      end
      tick();
      if32.issue_valid = 0; if32.flush = 0;
      n_cmp++;
      if ({if32.op_valid, if32.illegal, if32.busy} !== 3'b000) begin
        n_err++; $display("FAIL fidle_none[%0d]: got %b%b%b want 000", i,
                          if32.op_valid, if32.illegal, if32.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    start_mul32();
    for (int k = 1; k < 7; k++) tick();
    rst_n = 0;
    #1;
    got = {if32.mul_load, if32.mul_step, if32.hilo_we, if32.busy,
           if32.op_valid, if32.illegal, if32.hilo_valid,
           if32.op_sel != 2'b00, if32.op_funct != 6'd0};
    n_cmp++;
    if (got !== 9'd0) begin
      n_err++; $display("FAIL rmid_async: got %b want 000000000", got);
    end
    m_hv = 0; m_funct = 0; m_sel = 0;
    tick();
    rst_n = 1;
    tick();
    test_mul(1'b0);
  endtask

  task automatic test_mul_short();
    logic [4:0] got, exp;
    if1.issue_valid = 1; if1.issue_funct = 6'b011001; if1.flush = 0;
    tick();
    if1.issue_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      got = {if1.mul_load, if1.mul_step, if1.hilo_we,
             if1.issue_ready, if1.hilo_valid};
      exp = {k == 1, k == 2, k == 3, k >= 4, k >= 4};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mul1_seq k=%0d: got %b want %b",
                          k, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_ops();
    test_flush_run();
    test_flush_write();
    test_mul(1'b1);
    test_illegal_flush();
    test_reset_mid();
    test_mul_short();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Issue-side controller for the execution datapath. It accepts one funct code per handshake and routes single-cycle ops (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO) to the ALU, shifter or HI/LO mux with one cycle of registered latency. It runs the iterative multiplier through a load / step / write-back sequence of fixed length, back-pressuring issue until HI/LO is committed. It sits between instruction decode and the ALU/SHT/MUL/MUX units, replacing per-unit free-running cycle counting with one explicit FSM.

## Interface
Parameters:
- MUL_CYCLES, 32, number of multiplier step cycles (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  funct on issue_funct is presented
- issue_funct  in  6  funct code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MUL 011001, MFHI 010000, MFLO 010010
- issue_ready  out  1  sequencer accepts an op this cycle
- flush  in  1  synchronous abort of any in-flight operation
- op_valid  out  1  one-cycle pulse: op_funct/op_sel valid for the datapath
- op_funct  out  6  registered funct forwarded to the selected unit
- op_sel  out  2  result mux select: 00 ALU, 01 SHT, 10 HI, 11 LO
- illegal  out  1  one-cycle pulse: accepted funct not in the table
- mul_load  out  1  multiplier captures operands, clears product
- mul_step  out  1  multiplier performs one shift-add step
- hilo_we  out  1  HI/LO register write enable
- hilo_valid  out  1  HI/LO holds the result of a completed MUL
- busy  out  1  MUL sequence in progress (state ≠ IDLE)

## Operation
- Accept = issue_valid & issue_ready at a rising edge. issue_ready = (state==IDLE) & ~flush.
- FSM states: IDLE, LOAD, RUN, WRITE.
- IDLE + accept non-MUL legal funct: stay IDLE. Next cycle: op_valid=1, op_funct=funct, op_sel by class (ALU ops→00, SRL→01, MFHI→10, MFLO→11). Back-to-back issue allowed: one op per cycle.
- IDLE + accept illegal funct: next cycle illegal=1, op_valid=0, op_funct/op_sel hold.
- IDLE + accept MUL: →LOAD, clear step counter.
- LOAD: mul_load=1 for one cycle; →RUN.
- RUN: mul_step=1 every cycle. The step counter counts 0..MUL_CYCLES-1; at MUL_CYCLES-1 →WRITE.
- WRITE: hilo_we=1 for one cycle; set hilo_valid; →IDLE.
- mul_load, mul_step, hilo_we and busy are Moore decodes of state. op_valid, op_funct, op_sel and illegal are registers.
- flush: at the next edge, state→IDLE and the counter clears. A flush sampled in WRITE does not cancel that cycle's hilo_we (the write is committed at the same edge). A flush in LOAD or RUN leaves hilo_valid unchanged, and HI/LO is not written.
- flush and issue_valid in the same IDLE cycle: issue_ready=0, nothing accepted.
- MFHI/MFLO cannot be accepted while busy, so a dependent read always sees the committed product. An MFHI/MFLO with hilo_valid=0 is still executed normally; hilo_valid is status only.
- Step counter width: $clog2(MUL_CYCLES), minimum 1 bit. There is no wrap beyond MUL_CYCLES-1.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, op_valid=0, op_funct=0, op_sel=00, illegal=0, hilo_valid=0. Decoded outputs follow: mul_load=mul_step=hilo_we=busy=0, issue_ready=1 once rst_n is high.
- Non-MUL latency: accept at edge T → op_valid high in cycle T..T+1.
- MUL with accept at edge T:
  - LOAD in cycle T+1.
  - RUN for cycles T+2 … T+MUL_CYCLES+1.
  - WRITE in cycle T+MUL_CYCLES+2.
  - IDLE and issue_ready=1 from T+MUL_CYCLES+3.
  - Total occupancy is MUL_CYCLES+2 cycles.
- A MUL does not pulse op_valid.
- Reset mid-sequence aborts immediately with no hilo_we.

## Structure
- Shared package (exec_pkg): funct constants, op_sel encodings, FSM state enum. The ALU control and other decode blocks reuse these.
- One natural sub-module: mul_step_counter (load-clear, enable, terminal-count flag, parameterized by MUL_CYCLES).

## Test plan
- Reset then ADD, SLT, SRL, MFLO on consecutive cycles → four op_valid pulses one cycle later, op_sel 00, 00, 01, 11, issue_ready constantly 1.
- MUL accepted at T (MUL_CYCLES=32) → mul_load at T+1, mul_step high exactly 32 cycles, hilo_we at T+34, hilo_valid=1 from T+35, issue_ready=0 throughout T+1..T+34.
- MFHI held on issue_valid during a MUL → accepted at the first IDLE cycle (T+35), op_sel=10 the cycle after.
- flush at RUN step 10 → IDLE next cycle, no hilo_we, hilo_valid unchanged. flush in WRITE → hilo_we still pulses once.
- Funct 111111 accepted → illegal pulse, op_valid=0. flush together with issue_valid in IDLE → no accept, no pulse.
- rst_n asserted at RUN step 5 → all outputs at reset values asynchronously. After release, a new MUL completes the full 34-cycle sequence. Repeat with MUL_CYCLES=1 → LOAD, 1 RUN, WRITE.
